// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer_pkg
//  Purpose  : Shared constants for the 8-bit processor fetch/branch path:
//             instruction field positions, opcode encodings and the
//             sequencer state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  // Instruction layout: opcode in the top three bits, immediate below it.
  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int IMM_W   = 5;

  // Opcode encodings as decoded by the control unit.
  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_MFI = 3'b001;
  localparam logic [2:0] OP_MW  = 3'b010;
  localparam logic [2:0] OP_MR  = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_JCE = 3'b101;
  localparam logic [2:0] OP_MB  = 3'b110;
  localparam logic [2:0] OP_JCN = 3'b111;

  // Sequencer states.
  localparam int         SEQ_STATE_W = 3;
  localparam logic [2:0] SEQ_IDLE    = 3'd0;
  localparam logic [2:0] SEQ_FETCH   = 3'd1;
  localparam logic [2:0] SEQ_DECODE  = 3'd2;
  localparam logic [2:0] SEQ_EXEC    = 3'd3;
  localparam logic [2:0] SEQ_MEMWAIT = 3'd4;

  // A read and a write strobed together still cost a single memory wait.
  function automatic logic is_mem_op(input logic rm, input logic wm);
    return rm | wm;
  endfunction

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve
//  Purpose  : Combinational next-PC selection for one executed instruction.
//  Ports    : i_j, i_jc, i_neq  - branch strobes from the control unit
//             i_eq_flag         - ALU compare result
//             i_pc              - current program counter
//             i_imm             - 5-bit absolute branch target
//             o_pc_next         - PC to commit at the end of EXEC
//             o_taken           - branch taken indication
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              i_j,
  input  logic              i_jc,
  input  logic              i_neq,
  input  logic              i_eq_flag,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [PC_W-1:0]   o_pc_next,
  output logic              o_taken
);

  // Conditional jumps: neq inverts the sense, so JCE takes on eq=1 and
  // JCN takes on eq=0.
  assign o_taken = i_j | (i_jc & (i_eq_flag ^ i_neq));

  // Sequential increment wraps naturally at PC_W bits.
  assign o_pc_next = o_taken ? {{(PC_W-IMM_W){1'b0}}, i_imm}
                             : i_pc + PC_W'(1);

endmodule : branch_resolve
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Instruction fetch / branch sequencer. Fetches into the IR,
//             presents the opcode to the control unit, resolves branches,
//             commits via a one-cycle exec strobe and waits on data memory.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             run                      - enable, sampled in IDLE and at exits
//             imem_req/addr/valid/data - instruction memory handshake
//             opcode, instr            - IR fields to control unit / datapath
//             j, jc, neq, rm, wm       - control unit strobes
//             eq_flag                  - ALU compare result
//             dmem_done                - data memory completion
//             exec_en, pc, busy        - commit strobe, PC, activity
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [2:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  input  logic               j,
  input  logic               jc,
  input  logic               neq,
  input  logic               rm,
  input  logic               wm,
  input  logic               eq_flag,
  input  logic               dmem_done,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               busy
);

  logic [SEQ_STATE_W-1:0] r_state;
  logic [SEQ_STATE_W-1:0] w_state_next;
  logic [PC_W-1:0]        r_pc;
  logic [INSTR_W-1:0]     r_ir;
  logic [PC_W-1:0]        w_pc_next;
  logic                   w_taken;

  branch_resolve #(
    .PC_W (PC_W)
  ) u_branch_resolve (
    .i_j       (j),
    .i_jc      (jc),
    .i_neq     (neq),
    .i_eq_flag (eq_flag),
    .i_pc      (r_pc),
    .i_imm     (r_ir[IMM_W-1:0]),
    .o_pc_next (w_pc_next),
    .o_taken   (w_taken)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC and IR. A fetch in flight when rst hits is simply dropped; any late
  // imem_valid then arrives outside FETCH and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if ((r_state == SEQ_FETCH) && imem_valid) begin
        r_ir <= imem_data;
      end
      if (r_state == SEQ_EXEC) begin
        r_pc <= w_pc_next;
      end
    end
  end

  // Next-state logic. run is only consulted at instruction boundaries, so
  // dropping it mid-instruction lets the current instruction finish.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: begin
        if (run) w_state_next = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (imem_valid) w_state_next = SEQ_DECODE;
      end
      SEQ_DECODE: begin
        w_state_next = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (is_mem_op(rm, wm)) w_state_next = SEQ_MEMWAIT;
        else if (run)          w_state_next = SEQ_FETCH;
        else                   w_state_next = SEQ_IDLE;
      end
      SEQ_MEMWAIT: begin
        if (dmem_done) w_state_next = run ? SEQ_FETCH : SEQ_IDLE;
      end
      default: begin
        w_state_next = SEQ_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    imem_req  = (r_state == SEQ_FETCH);
    exec_en   = (r_state == SEQ_EXEC);
    busy      = (r_state != SEQ_IDLE);
    imem_addr = r_pc;
    pc        = r_pc;
    instr     = r_ir;
    opcode    = r_ir[OPC_MSB:OPC_LSB];
  end

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Self-checking bench for fetch_sequencer with an instruction-
//             level reference model and a simple control-unit decoder.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [2:0] opcode;
  logic [7:0] instr;
  logic       j, jc, neq, rm, wm;
  logic       eq_flag;
  logic       dmem_done;
  logic       exec_en;
  logic [7:0] pc;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int unsigned mpc = 0;   // reference program counter

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W    (8),
    .INSTR_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .instr      (instr),
    .j          (j),
    .jc         (jc),
    .neq        (neq),
    .rm         (rm),
    .wm         (wm),
    .eq_flag    (eq_flag),
    .dmem_done  (dmem_done),
    .exec_en    (exec_en),
    .pc         (pc),
    .busy       (busy)
  );

  // Control unit: strobes decoded straight from the presented opcode.
  always_comb begin
    j   = (opcode == 3'b100);
    jc  = (opcode == 3'b101) || (opcode == 3'b111);
    neq = (opcode == 3'b111);
    rm  = (opcode == 3'b011);
    wm  = (opcode == 3'b010);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave IDLE and land in FETCH.
  task automatic restart();
    run = 1'b1;
    step();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), mpc);
  endtask

  // Execute one instruction from the FETCH state. Expected behaviour is
  // derived from the instruction semantics, not from state tracking.
  task automatic do_instr(input logic [7:0] ins, input int wt, input logic eq,
                          input int md, input logic run_after, input logic stray);
    logic [2:0]  op;
    logic        taken;
    logic        mem;
    int unsigned exp_pc;
    op    = ins[7:5];
    taken = (op == 3'b100) || (op == 3'b101 && eq) || (op == 3'b111 && !eq);
    mem   = (op == 3'b010) || (op == 3'b011);
    exp_pc = taken ? 32'(ins[4:0]) : ((mpc + 1) % 256);

    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), mpc);
    for (int w = 0; w < wt; w++) begin
      imem_valid = 1'b0;
      dmem_done  = 1'($urandom_range(0, 1));   // must be ignored here
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_exec", 32'(exec_en), 32'd0);
    end
    dmem_done  = 1'b0;
    imem_valid = 1'b1;
    imem_data  = ins;
    step();
    // DECODE
    imem_valid = stray;
    imem_data  = stray ? 8'hFF : 8'($urandom);
    eq_flag    = eq;
    run        = run_after;
    chk("dec_req", 32'(imem_req), 32'd0);
    chk("dec_exec", 32'(exec_en), 32'd0);
    chk("dec_opcode", 32'(opcode), 32'(op));
    chk("dec_instr", 32'(instr), 32'(ins));
    step();
    // EXEC
    imem_valid = 1'b0;
    chk("exec_en", 32'(exec_en), 32'd1);
    chk("exec_instr", 32'(instr), 32'(ins));
    chk("exec_pc_old", 32'(pc), mpc);
    step();
    mpc = exp_pc;
    chk("pc_after", 32'(pc), mpc);
    chk("post_exec_en", 32'(exec_en), 32'd0);
    if (mem) begin
      for (int m = 0; m < md; m++) begin
        chk("mw_req", 32'(imem_req), 32'd0);
        chk("mw_busy", 32'(busy), 32'd1);
        chk("mw_exec", 32'(exec_en), 32'd0);
        step();
      end
      dmem_done = 1'b1;
      step();
      dmem_done = 1'b0;
    end
    if (run_after) chk("next_req", 32'(imem_req), 32'd1);
    else           chk("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b1;
    imem_valid = 1'b0;
    imem_data  = 8'h00;
    eq_flag    = 1'b0;
    dmem_done  = 1'b0;

    // T1 reset
    step();
    step();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_exec", 32'(exec_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_busy", 32'(busy), 32'd1);

    // T2 straight line, zero-wait
    do_instr(8'h00, 0, 1'b0, 0, 1'b1, 1'b0);
    do_instr(8'h20, 0, 1'b0, 0, 1'b1, 1'b0);

    // T3 branches
    do_instr(8'h85, 0, 1'b0, 0, 1'b1, 1'b0);
    do_instr(8'hA3, 1, 1'b1, 0, 1'b1, 1'b0);
    do_instr(8'hA3, 0, 1'b0, 0, 1'b1, 1'b0);
    do_instr(8'hE3, 2, 1'b0, 0, 1'b1, 1'b0);
    do_instr(8'hE3, 0, 1'b1, 0, 1'b1, 1'b0);

    // T5 memory read with three MEMWAIT cycles before done
    do_instr(8'h60, 0, 1'b0, 3, 1'b1, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      do_instr(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 3)), 1'b1, 1'($urandom_range(0, 1)));
    end

    // T4 wrap: walk to 0xFF with non-branch instructions, then wrap
    for (int k = 0; k < 256 && mpc != 255; k++) begin
      do_instr(8'h20, 0, 1'b0, 0, 1'b1, 1'b0);
    end
    chk("pre_wrap_pc", 32'(pc), 32'd255);
    do_instr(8'h00, 0, 1'b0, 0, 1'b1, 1'b1);
    chk("wrap_pc", 32'(pc), 32'd0);

    // T6a reset during FETCH, late valid ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    run = 1'b0;
    mpc = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd0);
    step();
    imem_valid = 1'b1;
    imem_data  = 8'hAA;
    step();
    imem_valid = 1'b0;
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_ir", 32'(instr), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);

    // T6b run dropped in DECODE: instruction completes, then IDLE
    restart();
    do_instr(8'h20, 1, 1'b0, 0, 1'b0, 1'b0);
    step();
    chk("t6_stay_idle", 32'(busy), 32'd0);
    chk("t6_pc_hold", 32'(pc), mpc);

    // Run dropped before a memory op exit
    restart();
    do_instr(8'h40, 0, 1'b0, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
